// File: rtl/ibex_wb_queue_pkg.sv
// Shared types for the ibex writeback queue: instruction classification
// as seen by the writeback stage.
package ibex_wb_queue_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

endpackage

// File: rtl/ibex_wb_queue.sv
// Multi-entry in-order writeback queue with per-port hazard detection and youngest-match forwarding.
// Optional performance counters are built when IBEX_WB_QUEUE_PERF_EN is defined.
module ibex_wb_queue
  import ibex_wb_queue_pkg::*;
#(
  parameter int unsigned Depth     = 2,
  parameter bit          ForwardEn = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,

  input  logic           en_wb_i,
  input  wb_instr_type_e instr_type_wb_i,
  input  logic [31:0]    pc_id_i,
  input  logic [4:0]     rf_waddr_id_i,
  input  logic [31:0]    rf_wdata_id_i,
  input  logic           rf_we_id_i,

  input  logic [4:0]     rf_raddr_a_i,
  input  logic [4:0]     rf_raddr_b_i,

  input  logic           lsu_data_valid_i,
  input  logic [31:0]    rf_wdata_lsu_i,
  input  logic           rf_we_lsu_i,

  output logic           ready_wb_o,
  output logic           mem_pending_o,
  output logic           outstanding_load_wb_o,
  output logic           outstanding_store_wb_o,
  output logic [31:0]    pc_wb_o,

  output logic           fwd_a_valid_o,
  output logic           fwd_b_valid_o,
  output logic [31:0]    fwd_a_data_o,
  output logic [31:0]    fwd_b_data_o,
  output logic           hazard_a_o,
  output logic           hazard_b_o,

  output logic [4:0]     rf_waddr_wb_o,
  output logic [31:0]    rf_wdata_wb_o,
  output logic           rf_we_wb_o,
  output logic           instr_done_wb_o
`ifdef IBEX_WB_QUEUE_PERF_EN
  ,
  output logic           perf_wb_stall_o,
  output logic [31:0]    perf_wb_full_cycles_o
`endif
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  // Pointers wrap at Depth, not at a power of two
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] age_slot(input logic [PtrW-1:0] base,
                                               input int unsigned     ofs);
    int unsigned s;
    s = 32'(base) + ofs;
    if (s >= Depth) begin
      s = s - Depth;
    end
    return PtrW'(s);
  endfunction

  logic                 q_we    [Depth];
  logic [4:0]           q_waddr [Depth];
  logic [31:0]          q_wdata [Depth];
  wb_instr_type_e       q_type  [Depth];
  logic [31:0]          q_pc    [Depth];

  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;

  logic                 head_valid, head_done, head_q_write;
  logic                 push, pop;
  logic                 mem_pending;
  logic [PtrW-1:0]      slot;
  logic [4:0]           raddr    [2];
  logic [1:0]           hit, hit_other;
  logic [1:0][31:0]     hit_data;

  assign head_valid   = (count_q != '0);
  assign head_done    = head_valid &
                        ((q_type[rd_ptr_q] == WB_INSTR_OTHER) | lsu_data_valid_i);
  assign head_q_write = head_done & (q_type[rd_ptr_q] == WB_INSTR_OTHER) & q_we[rd_ptr_q];

  // A full queue still accepts when the head leaves in the same cycle
  assign ready_wb_o = (count_q < CntW'(Depth)) | head_done;
  assign push       = en_wb_i & ready_wb_o;
  assign pop        = head_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_we[wr_ptr_q]    <= rf_we_id_i;
      q_waddr[wr_ptr_q] <= rf_waddr_id_i;
      q_wdata[wr_ptr_q] <= rf_wdata_id_i;
      q_type[wr_ptr_q]  <= instr_type_wb_i;
      q_pc[wr_ptr_q]    <= pc_id_i;
    end
  end

  assign raddr[0] = rf_raddr_a_i;
  assign raddr[1] = rf_raddr_b_i;

  // Walk oldest to youngest so the last match seen is the youngest producer
  always_comb begin
    hit         = '0;
    hit_other   = '0;
    hit_data    = '0;
    mem_pending = 1'b0;
    slot        = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      slot = age_slot(rd_ptr_q, i);
      if (CntW'(i) < count_q) begin
        if (q_type[slot] != WB_INSTR_OTHER) begin
          mem_pending = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
          if ((raddr[p] != 5'd0) && (q_waddr[slot] == raddr[p]) &&
              (q_we[slot] || (q_type[slot] == WB_INSTR_LOAD))) begin
            hit[p]       = 1'b1;
            hit_other[p] = (q_type[slot] == WB_INSTR_OTHER);
            hit_data[p]  = q_wdata[slot];
          end
        end
      end
    end
  end

  assign fwd_a_valid_o = hit[0] & hit_other[0] & ForwardEn;
  assign fwd_b_valid_o = hit[1] & hit_other[1] & ForwardEn;
  assign fwd_a_data_o  = fwd_a_valid_o ? hit_data[0] : 32'd0;
  assign fwd_b_data_o  = fwd_b_valid_o ? hit_data[1] : 32'd0;
  assign hazard_a_o    = hit[0] & ~fwd_a_valid_o;
  assign hazard_b_o    = hit[1] & ~fwd_b_valid_o;

  assign mem_pending_o          = mem_pending;
  assign outstanding_load_wb_o  = head_valid & (q_type[rd_ptr_q] == WB_INSTR_LOAD);
  assign outstanding_store_wb_o = head_valid & (q_type[rd_ptr_q] == WB_INSTR_STORE);
  assign pc_wb_o                = head_valid ? q_pc[rd_ptr_q] : 32'd0;

  // Queue and LSU writes are mutually exclusive, so a simple select suffices
  assign rf_we_wb_o      = head_q_write | rf_we_lsu_i;
  assign rf_wdata_wb_o   = head_q_write ? q_wdata[rd_ptr_q] : rf_wdata_lsu_i;
  assign rf_waddr_wb_o   = head_valid ? q_waddr[rd_ptr_q] : 5'd0;
  assign instr_done_wb_o = head_done;

`ifdef IBEX_WB_QUEUE_PERF_EN
  logic [31:0] full_cycles_q;

  assign perf_wb_stall_o = en_wb_i & ~ready_wb_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_cycles_q <= '0;
    end else if ((count_q == CntW'(Depth)) && (full_cycles_q != '1)) begin
      full_cycles_q <= full_cycles_q + 32'd1;
    end
  end

  assign perf_wb_full_cycles_o = full_cycles_q;
`endif

  // ID/EX must hold back memory ops while one is queued; LSU responses only target a memory head
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (en_wb_i && ready_wb_o && (instr_type_wb_i != WB_INSTR_OTHER)) |-> !mem_pending_o);

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lsu_data_valid_i && head_valid) |-> (q_type[rd_ptr_q] != WB_INSTR_OTHER));

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Self-checking bench for ibex_wb_queue: directed scenarios on Depth=2 and Depth=3
// instances plus randomized traffic on Depth=3 against a queue-based reference model.
module tb_ibex_wb_queue;
  import ibex_wb_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Depth=2 instance signals
  logic           en2, we2, lsuv2, lsuwe2;
  wb_instr_type_e ty2;
  logic [31:0]    pc2, wd2, lsud2;
  logic [4:0]     wa2, ra2, rb2;
  logic           rdy2, memp2, ol2, os2, fav2, fbv2, hza2, hzb2, rwe2, done2;
  logic [31:0]    pcwb2, fad2, fbd2, rwd2;
  logic [4:0]     rwa2;
`ifdef IBEX_WB_QUEUE_PERF_EN
  logic           stall2;
  logic [31:0]    fullc2;
`endif

  // Depth=3 instance signals
  logic           en3, we3, lsuv3, lsuwe3;
  wb_instr_type_e ty3;
  logic [31:0]    pc3, wd3, lsud3;
  logic [4:0]     wa3, ra3, rb3;
  logic           rdy3, memp3, ol3, os3, fav3, fbv3, hza3, hzb3, rwe3, done3;
  logic [31:0]    pcwb3, fad3, fbd3, rwd3;
  logic [4:0]     rwa3;
`ifdef IBEX_WB_QUEUE_PERF_EN
  logic           stall3;
  logic [31:0]    fullc3;
`endif

  ibex_wb_queue #(.Depth(2), .ForwardEn(1'b1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .en_wb_i(en2), .instr_type_wb_i(ty2), .pc_id_i(pc2), .rf_waddr_id_i(wa2),
    .rf_wdata_id_i(wd2), .rf_we_id_i(we2), .rf_raddr_a_i(ra2), .rf_raddr_b_i(rb2),
    .lsu_data_valid_i(lsuv2), .rf_wdata_lsu_i(lsud2), .rf_we_lsu_i(lsuwe2),
    .ready_wb_o(rdy2), .mem_pending_o(memp2), .outstanding_load_wb_o(ol2),
    .outstanding_store_wb_o(os2), .pc_wb_o(pcwb2),
    .fwd_a_valid_o(fav2), .fwd_b_valid_o(fbv2), .fwd_a_data_o(fad2), .fwd_b_data_o(fbd2),
    .hazard_a_o(hza2), .hazard_b_o(hzb2),
    .rf_waddr_wb_o(rwa2), .rf_wdata_wb_o(rwd2), .rf_we_wb_o(rwe2), .instr_done_wb_o(done2)
`ifdef IBEX_WB_QUEUE_PERF_EN
    , .perf_wb_stall_o(stall2), .perf_wb_full_cycles_o(fullc2)
`endif
  );

  ibex_wb_queue #(.Depth(3), .ForwardEn(1'b1)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .en_wb_i(en3), .instr_type_wb_i(ty3), .pc_id_i(pc3), .rf_waddr_id_i(wa3),
    .rf_wdata_id_i(wd3), .rf_we_id_i(we3), .rf_raddr_a_i(ra3), .rf_raddr_b_i(rb3),
    .lsu_data_valid_i(lsuv3), .rf_wdata_lsu_i(lsud3), .rf_we_lsu_i(lsuwe3),
    .ready_wb_o(rdy3), .mem_pending_o(memp3), .outstanding_load_wb_o(ol3),
    .outstanding_store_wb_o(os3), .pc_wb_o(pcwb3),
    .fwd_a_valid_o(fav3), .fwd_b_valid_o(fbv3), .fwd_a_data_o(fad3), .fwd_b_data_o(fbd3),
    .hazard_a_o(hza3), .hazard_b_o(hzb3),
    .rf_waddr_wb_o(rwa3), .rf_wdata_wb_o(rwd3), .rf_we_wb_o(rwe3), .instr_done_wb_o(done3)
`ifdef IBEX_WB_QUEUE_PERF_EN
    , .perf_wb_stall_o(stall3), .perf_wb_full_cycles_o(fullc3)
`endif
  );

  typedef struct {
    logic           we;
    logic [4:0]     wa;
    logic [31:0]    wd;
    wb_instr_type_e ty;
    logic [31:0]    pc;
  } ent_t;

  ent_t mq[$];

  task automatic idle2();
    en2 = 1'b0; ty2 = WB_INSTR_OTHER; pc2 = '0; wa2 = '0; wd2 = '0; we2 = 1'b0;
    ra2 = '0; rb2 = '0; lsuv2 = 1'b0; lsud2 = '0; lsuwe2 = 1'b0;
  endtask

  task automatic idle3();
    en3 = 1'b0; ty3 = WB_INSTR_OTHER; pc3 = '0; wa3 = '0; wd3 = '0; we3 = 1'b0;
    ra3 = '0; rb3 = '0; lsuv3 = 1'b0; lsud3 = '0; lsuwe3 = 1'b0;
  endtask

  task automatic issue2(input wb_instr_type_e t, input logic [31:0] pc, input logic [4:0] wa,
                        input logic [31:0] wd, input logic we);
    en2 = 1'b1; ty2 = t; pc2 = pc; wa2 = wa; wd2 = wd; we2 = we;
  endtask

  task automatic issue3(input wb_instr_type_e t, input logic [31:0] pc, input logic [4:0] wa,
                        input logic [31:0] wd, input logic we);
    en3 = 1'b1; ty3 = t; pc3 = pc; wa3 = wa; wd3 = wd; we3 = we;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle2();
    idle3();
    #2;
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", rdy2); end
    checks++; if (rwe2 !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", rwe2); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done2); end
    checks++; if ({memp2, ol2, os2} !== 3'b000) begin errors++; $display("FAIL reset_mem_flags: got %03b want 000", {memp2, ol2, os2}); end
    checks++; if (pcwb2 !== 32'd0) begin errors++; $display("FAIL reset_pc_wb: got %08h want 0", pcwb2); end
    checks++; if ({fav2, fbv2, hza2, hzb2} !== 4'b0000) begin errors++; $display("FAIL reset_fwd_flags: got %04b want 0000", {fav2, fbv2, hza2, hzb2}); end
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL reset_ready_d3: got %0b want 1", rdy3); end
`ifdef IBEX_WB_QUEUE_PERF_EN
    checks++; if (fullc2 !== 32'd0) begin errors++; $display("FAIL reset_perf_full: got %0d want 0", fullc2); end
    checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL reset_perf_stall: got %0b want 0", stall2); end
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    issue2(WB_INSTR_OTHER, 32'h100, 5'd1, 32'hA5A5_0001, 1'b1);
    @(negedge clk);
    checks++; if (rwe2 !== 1'b0) begin errors++; $display("FAIL b2b_c0_we: got %0b want 0", rwe2); end
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL b2b_c0_ready: got %0b want 1", rdy2); end
    next_cycle();
    issue2(WB_INSTR_OTHER, 32'h104, 5'd2, 32'h0000_0002, 1'b1);
    @(negedge clk);
    checks++; if ({rwe2, done2, rdy2} !== 3'b111) begin errors++; $display("FAIL b2b_c1_flags: got %03b want 111", {rwe2, done2, rdy2}); end
    checks++; if (rwa2 !== 5'd1 || rwd2 !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_c1_write: got x%0d=%08h want x1=a5a50001", rwa2, rwd2); end
    checks++; if (pcwb2 !== 32'h100) begin errors++; $display("FAIL b2b_c1_pc: got %08h want 00000100", pcwb2); end
    next_cycle();
    idle2();
    @(negedge clk);
    checks++; if ({rwe2, done2, rdy2} !== 3'b111) begin errors++; $display("FAIL b2b_c2_flags: got %03b want 111", {rwe2, done2, rdy2}); end
    checks++; if (rwa2 !== 5'd2 || rwd2 !== 32'h2) begin errors++; $display("FAIL b2b_c2_write: got x%0d=%08h want x2=00000002", rwa2, rwd2); end
    next_cycle();
    @(negedge clk);
    checks++; if ({rwe2, done2} !== 2'b00) begin errors++; $display("FAIL b2b_c3_idle: got %02b want 00", {rwe2, done2}); end
    next_cycle();
  endtask

  task automatic test_load_stall();
    issue2(WB_INSTR_LOAD, 32'h200, 5'd3, 32'h0, 1'b1);
    next_cycle();
    issue2(WB_INSTR_OTHER, 32'h204, 5'd4, 32'h44, 1'b1);
    @(negedge clk);
    checks++; if ({ol2, rdy2, done2} !== 3'b110) begin errors++; $display("FAIL ld_c1_flags: got %03b want 110", {ol2, rdy2, done2}); end
    checks++; if (pcwb2 !== 32'h200) begin errors++; $display("FAIL ld_c1_pc: got %08h want 00000200", pcwb2); end
    next_cycle();
    issue2(WB_INSTR_OTHER, 32'h208, 5'd7, 32'h77, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({rdy2, done2, ol2, memp2, rwe2} !== 5'b00110) begin errors++; $display("FAIL ld_stall_%0d: got rdy/done/ol/memp/we=%05b want 00110", c, {rdy2, done2, ol2, memp2, rwe2}); end
      next_cycle();
    end
    lsuv2 = 1'b1; lsuwe2 = 1'b1; lsud2 = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({rwe2, done2, rdy2} !== 3'b111) begin errors++; $display("FAIL ld_resp_flags: got %03b want 111", {rwe2, done2, rdy2}); end
    checks++; if (rwa2 !== 5'd3 || rwd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_resp_write: got x%0d=%08h want x3=deadbeef", rwa2, rwd2); end
    next_cycle();
    idle2();
    @(negedge clk);
    checks++; if (rwe2 !== 1'b1 || rwa2 !== 5'd4 || rwd2 !== 32'h44) begin errors++; $display("FAIL ld_x4_write: got we=%0b x%0d=%08h want we=1 x4=00000044", rwe2, rwa2, rwd2); end
    checks++; if (ol2 !== 1'b0) begin errors++; $display("FAIL ld_x4_outstanding: got %0b want 0", ol2); end
    next_cycle();
    @(negedge clk);
    checks++; if (rwe2 !== 1'b1 || rwa2 !== 5'd7 || rwd2 !== 32'h77) begin errors++; $display("FAIL ld_x7_write: got we=%0b x%0d=%08h want we=1 x7=00000077", rwe2, rwa2, rwd2); end
    next_cycle();
    @(negedge clk);
    checks++; if ({rwe2, rdy2, memp2} !== 3'b010) begin errors++; $display("FAIL ld_drained: got we/rdy/memp=%03b want 010", {rwe2, rdy2, memp2}); end
    next_cycle();
  endtask

  task automatic test_forward();
    issue3(WB_INSTR_LOAD, 32'h300, 5'd6, 32'h0, 1'b1);
    next_cycle();
    issue3(WB_INSTR_OTHER, 32'h304, 5'd5, 32'h1234, 1'b1);
    next_cycle();
    issue3(WB_INSTR_OTHER, 32'h308, 5'd5, 32'h5678, 1'b1);
    ra3 = 5'd5;
    @(negedge clk);
    checks++; if (fav3 !== 1'b1 || fad3 !== 32'h1234) begin errors++; $display("FAIL fwd_no_bypass: got v=%0b d=%08h want v=1 d=00001234", fav3, fad3); end
    next_cycle();
    en3 = 1'b0; ra3 = 5'd5; rb3 = 5'd6;
    @(negedge clk);
    checks++; if (fav3 !== 1'b1 || fad3 !== 32'h5678 || hza3 !== 1'b0) begin errors++; $display("FAIL fwd_youngest: got v=%0b d=%08h hz=%0b want v=1 d=00005678 hz=0", fav3, fad3, hza3); end
    checks++; if (hzb3 !== 1'b1 || fbv3 !== 1'b0) begin errors++; $display("FAIL fwd_load_hazard: got hz=%0b v=%0b want hz=1 v=0", hzb3, fbv3); end
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL fwd_full_ready: got %0b want 0", rdy3); end
    ra3 = 5'd0; rb3 = 5'd0;
    #1;
    checks++; if ({fav3, fbv3, hza3, hzb3} !== 4'b0000) begin errors++; $display("FAIL fwd_x0: got %04b want 0000", {fav3, fbv3, hza3, hzb3}); end
    next_cycle();
    lsuv3 = 1'b1; lsuwe3 = 1'b1; lsud3 = 32'h6666_0006;
    next_cycle();
    idle3();
    repeat (3) next_cycle();
  endtask

  task automatic test_random_wrap();
    bit             has_mem, head_mem, e_done, e_ready, e_qw, e_we, hit, efv, ehz, afv, ahz;
    logic [31:0]    e_wd, e_pc, afd;
    logic [4:0]     e_wa, rr;
    int             r;
    ent_t           win;
    ent_t           ne;
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      has_mem = 1'b0;
      foreach (mq[k]) if (mq[k].ty != WB_INSTR_OTHER) has_mem = 1'b1;
      head_mem = (mq.size() > 0) && (mq[0].ty != WB_INSTR_OTHER);
      r = int'($urandom_range(0, 5));
      en3 = ($urandom_range(0, 9) < 7);
      ty3 = (!has_mem && r == 0) ? WB_INSTR_LOAD : (!has_mem && r == 1) ? WB_INSTR_STORE : WB_INSTR_OTHER;
      we3 = (ty3 == WB_INSTR_STORE) ? 1'b0 : ($urandom_range(0, 4) != 0);
      wa3 = 5'($urandom_range(0, 3));
      wd3 = $urandom;
      pc3 = $urandom & 32'hFFFF_FFFC;
      ra3 = 5'($urandom_range(0, 3));
      rb3 = 5'($urandom_range(0, 3));
      lsuv3 = head_mem && ($urandom_range(0, 2) == 0);
      lsuwe3 = lsuv3 && (mq[0].ty == WB_INSTR_LOAD) && mq[0].we;
      lsud3 = $urandom;

      e_done  = (mq.size() > 0) && ((mq[0].ty == WB_INSTR_OTHER) || lsuv3);
      e_ready = (mq.size() < 3) || e_done;
      e_qw    = e_done && (mq[0].ty == WB_INSTR_OTHER) && mq[0].we;
      e_we    = e_qw || lsuwe3;
      e_wd    = e_qw ? mq[0].wd : lsud3;
      e_wa    = (mq.size() > 0) ? mq[0].wa : 5'd0;
      e_pc    = (mq.size() > 0) ? mq[0].pc : 32'd0;

      @(negedge clk);
      checks++; if (rdy3 !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %0b want %0b", cyc, rdy3, e_ready); end
      checks++; if (done3 !== e_done) begin errors++; $display("FAIL rnd_done c%0d: got %0b want %0b", cyc, done3, e_done); end
      checks++; if (rwe3 !== e_we || rwd3 !== e_wd || rwa3 !== e_wa) begin errors++; $display("FAIL rnd_rfwrite c%0d: got we=%0b x%0d=%08h want we=%0b x%0d=%08h", cyc, rwe3, rwa3, rwd3, e_we, e_wa, e_wd); end
      checks++; if (pcwb3 !== e_pc) begin errors++; $display("FAIL rnd_pc c%0d: got %08h want %08h", cyc, pcwb3, e_pc); end
      checks++; if (memp3 !== has_mem || ol3 !== (head_mem && mq[0].ty == WB_INSTR_LOAD) || os3 !== (head_mem && mq[0].ty == WB_INSTR_STORE)) begin
        errors++; $display("FAIL rnd_memflags c%0d: got memp/ol/os=%0b%0b%0b", cyc, memp3, ol3, os3);
      end
      for (int p = 0; p < 2; p++) begin
        rr  = (p == 0) ? ra3 : rb3;
        hit = 1'b0;
        for (int k = mq.size() - 1; k >= 0; k--) begin
          if (!hit && rr != 5'd0 && mq[k].wa == rr && (mq[k].we || mq[k].ty == WB_INSTR_LOAD)) begin
            hit = 1'b1;
            win = mq[k];
          end
        end
        efv = hit && (win.ty == WB_INSTR_OTHER);
        ehz = hit && !efv;
        afv = (p == 0) ? fav3 : fbv3;
        ahz = (p == 0) ? hza3 : hzb3;
        afd = (p == 0) ? fad3 : fbd3;
        checks++; if (afv !== efv || ahz !== ehz) begin errors++; $display("FAIL rnd_fwdflags c%0d p%0d: got v=%0b hz=%0b want v=%0b hz=%0b", cyc, p, afv, ahz, efv, ehz); end
        if (efv) begin
          checks++; if (afd !== win.wd) begin errors++; $display("FAIL rnd_fwddata c%0d p%0d: got %08h want %08h", cyc, p, afd, win.wd); end
        end
      end
      @(posedge clk);
      #1;
      if (e_done) void'(mq.pop_front());
      if (en3 && e_ready) begin
        ne.we = we3; ne.wa = wa3; ne.wd = wd3; ne.ty = ty3; ne.pc = pc3;
        mq.push_back(ne);
      end
    end
    idle3();
    if (mq.size() > 0 && mq[0].ty != WB_INSTR_OTHER) lsuv3 = 1'b1;
    next_cycle();
    idle3();
    repeat (4) next_cycle();
  endtask

`ifdef IBEX_WB_QUEUE_PERF_EN
  task automatic test_perf();
    logic [31:0] p0;
    issue2(WB_INSTR_LOAD, 32'h500, 5'd3, 32'h0, 1'b1);
    next_cycle();
    issue2(WB_INSTR_OTHER, 32'h504, 5'd4, 32'h4, 1'b1);
    next_cycle();
    issue2(WB_INSTR_OTHER, 32'h508, 5'd8, 32'h8, 1'b1);
    @(negedge clk);
    p0 = fullc2;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (stall2 !== 1'b1) begin errors++; $display("FAIL perf_stall_%0d: got %0b want 1", c, stall2); end
      next_cycle();
    end
    en2 = 1'b0;
    @(negedge clk);
    checks++; if (fullc2 !== p0 + 32'd4) begin errors++; $display("FAIL perf_full_cycles: got %0d want %0d", fullc2, p0 + 32'd4); end
    checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL perf_stall_off: got %0b want 0", stall2); end
    lsuv2 = 1'b1; lsuwe2 = 1'b1; lsud2 = 32'h3;
    next_cycle();
    idle2();
    repeat (3) next_cycle();
  endtask
`endif

  task automatic test_reset_mid();
    issue2(WB_INSTR_STORE, 32'h400, 5'd0, 32'h0, 1'b0);
    next_cycle();
    issue2(WB_INSTR_OTHER, 32'h404, 5'd9, 32'h99, 1'b1);
    next_cycle();
    idle2();
    @(negedge clk);
    checks++; if ({rdy2, os2, memp2} !== 3'b011) begin errors++; $display("FAIL rst_pre_full: got rdy/os/memp=%03b want 011", {rdy2, os2, memp2}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rdy2, os2, memp2, rwe2, done2} !== 5'b10000) begin errors++; $display("FAIL rst_async: got rdy/os/memp/we/done=%05b want 10000", {rdy2, os2, memp2, rwe2, done2}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({rdy2, os2, memp2, rwe2} !== 4'b1000) begin errors++; $display("FAIL rst_next: got rdy/os/memp/we=%04b want 1000", {rdy2, os2, memp2, rwe2}); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    lsuv2 = 1'b1; lsuwe2 = 1'b1; lsud2 = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if (done2 !== 1'b0 || rwe2 !== 1'b1 || rwd2 !== 32'hCAFE_0001) begin errors++; $display("FAIL rst_stale_lsu: got done=%0b we=%0b d=%08h want done=0 we=1 d=cafe0001", done2, rwe2, rwd2); end
    next_cycle();
    idle2();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_stall();
    test_forward();
    test_random_wrap();
`ifdef IBEX_WB_QUEUE_PERF_EN
    test_perf();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_wb_queue.md
Name: ibex_wb_queue

Overview:
- Parametrised multi-entry writeback stage between ID/EX and the register file.
- Holds up to Depth completed-or-pending instructions and retires them strictly in order, at most one per cycle.
- Non-memory results are written from the queue. Load data is written by the LSU when its response arrives.
- Provides per-read-port hazard detection and youngest-match forwarding to ID, so ID/EX does not stall while older instructions drain.

Parameters:
- Depth, 2, number of queue entries; legal range 1..8.
- ForwardEn, 1'b1, enables forwarding from queued non-load entries; when 0, any matching entry raises the hazard output.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- en_wb_i  in  1  ID/EX offers an instruction this cycle
- instr_type_wb_i  in  wb_instr_type_e  WB_INSTR_LOAD / WB_INSTR_STORE / WB_INSTR_OTHER
- pc_id_i  in  32  PC of offered instruction
- rf_waddr_id_i  in  5  destination register
- rf_wdata_id_i  in  32  result data (non-load)
- rf_we_id_i  in  1  instruction writes the RF
- rf_raddr_a_i, rf_raddr_b_i  in  5 each  ID read addresses for hazard/forward check
- lsu_data_valid_i  in  1  LSU response for the oldest memory entry
- rf_wdata_lsu_i  in  32  load data
- rf_we_lsu_i  in  1  LSU writes the RF
- ready_wb_o  out  1  queue accepts an entry this cycle
- mem_pending_o  out  1  a load or store entry is in the queue
- outstanding_load_wb_o, outstanding_store_wb_o  out  1 each  head is a load / store awaiting response
- pc_wb_o  out  32  PC of head entry
- fwd_a_valid_o, fwd_b_valid_o  out  1 each  forward data valid for port a/b
- fwd_a_data_o, fwd_b_data_o  out  32 each  forwarded data
- hazard_a_o, hazard_b_o  out  1 each  port a/b depends on an unforwardable entry
- rf_waddr_wb_o  out  5  RF write address
- rf_wdata_wb_o  out  32  RF write data
- rf_we_wb_o  out  1  RF write enable
- instr_done_wb_o  out  1  head retired this cycle

Behaviour:
- Storage: circular buffer. Each entry holds {we, waddr, wdata, type, pc}. Write pointer, read pointer, and an occupancy counter of width $clog2(Depth+1).
- Reset values:
  - queue empty; all pointers 0.
  - ready_wb_o = 1.
  - All other outputs 0; pc_wb_o = 0.
  - Entry payload registers are not reset.
- Enqueue: en_wb_i & ready_wb_o writes the tail. The entry is visible to the hazard/forward logic from the next cycle; there is no same-cycle bypass.
- ready_wb_o = (count < Depth) | head_done. A full queue that retires its head accepts in the same cycle.
- Head completion:
  - head_done = head_valid & (type==OTHER | lsu_data_valid_i).
  - Retire pops the head. instr_done_wb_o = head_done.
- Pointers wrap modulo Depth; non-power-of-2 Depth is supported.
- Simultaneous enqueue and retire: count unchanged. A single-entry queue (Depth=1) sustains 1 instr/cycle for OTHER.
- RF write:
  - Queue write when the head is OTHER, rf_we is set, and it retires.
  - LSU write on rf_we_lsu_i.
  - rf_we_wb_o = OR of both. rf_wdata_wb_o selects the queue source when the queue write is active.
  - rf_waddr_wb_o = head waddr.
- Ordering invariant:
  - At most one memory entry is in the queue; ID/EX stalls new memory ops while mem_pending_o = 1.
  - lsu_data_valid_i is only legal when the head is a memory entry, so queue and LSU writes never coincide.
  - Both rules are asserted.
- Hazard/forward for each port p, with raddr != 0:
  - Scan entries; the youngest entry with matching waddr and (we | type==LOAD) wins.
  - If the winner is OTHER and ForwardEn: fwd_p_valid_o = 1, fwd_p_data_o = winner wdata.
  - Else if a winner exists: hazard_p_o = 1.
  - raddr == 0 never matches.
- outstanding_load_wb_o = head_valid & head type LOAD; outstanding_store_wb_o likewise for STORE.
- pc_wb_o = head pc when the queue is non-empty, else 0.
- Reset asserted mid-operation empties the queue immediately. A later LSU response with an empty queue is ignored for retirement; its LSU write still propagates.

Optional Feature:
- Macro IBEX_WB_QUEUE_PERF_EN.
- Defined:
  - adds output perf_wb_stall_o (1), asserted each cycle en_wb_i & ~ready_wb_o.
  - adds output perf_wb_full_cycles_o (32), a saturating count of cycles with count==Depth; reset 0.
- Undefined: neither port exists; no counter logic is generated.

Test Plan:
- Depth=2, issue OTHER x1←0xA5A5_0001 then x2←0x0000_0002 on consecutive cycles, no stalls -> rf_we_wb_o pulses on the two following cycles with those address/data pairs; instr_done_wb_o=1 both cycles; ready_wb_o stays 1.
- LOAD x3 at head, then OTHER x4, then a third OTHER with Depth=2, lsu_data_valid_i held low 5 cycles -> ready_wb_o=0 after two entries; outstanding_load_wb_o=1. Raise lsu_data_valid_i with rf_wdata_lsu_i=0xDEAD_BEEF -> x3 is written, the third entry enqueues in the same cycle, x4 is written next cycle.
- Queued OTHER x5=0x1234 older and OTHER x5=0x5678 younger, rf_raddr_a_i=5 -> fwd_a_valid_o=1, fwd_a_data_o=0x5678, hazard_a_o=0. Pending LOAD x6 with rf_raddr_b_i=6 -> hazard_b_o=1. rf_raddr=0 -> no flags.
- Depth=3 wrap: enqueue/retire 7 OTHERs with occasional en_wb_i gaps -> in-order RF writes and correct pc_wb_o sequence.
- Assert rst_ni low while the queue is full with a pending STORE -> next cycle ready_wb_o=1, outstanding_store_wb_o=0, mem_pending_o=0, no RF write.
- With IBEX_WB_QUEUE_PERF_EN: hold a full queue for 4 cycles with en_wb_i=1 -> perf_wb_stall_o=1 for 4 cycles; perf_wb_full_cycles_o increments by 4.
